// File: rtl/cas_fsk_separator.sv
// Cassette FSK separator: filters cas_in, times edge gaps, drives legacy rxd/rxc and framed bits.
// Edges land FILTER_LEN ticks after the synchroniser; bit_valid follows the classifying tick by one clk.
module cas_fsk_separator #(
  parameter int CLK_DIV      = 2,
  parameter int FILTER_LEN   = 4,
  parameter int CNT_W        = 10,
  parameter int BURST0_AT    = 8,
  parameter int LONG_MIN     = 176,
  parameter int GAP_MAX      = 600,
  parameter int BURST_PULSES = 4,
  parameter int HT_DIV       = 256,
  parameter int HT_THRESHOLD = 445,
  parameter int HT_CNT_W     = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic mode_300,
  input  logic invert,
  input  logic cas_in,
  output logic rxd,
  output logic rxc,
  output logic bit_valid,
  output logic bit_data,
  output logic carrier,
  output logic high_tone
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int BW = $clog2(2 * BURST_PULSES + 1);
  localparam int HW = (HT_DIV > 1) ? $clog2(HT_DIV) : 1;

  localparam logic [CNT_W-1:0]    GAP_MAX_V  = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0]    LONG_MIN_V = CNT_W'(LONG_MIN);
  localparam logic [CNT_W-1:0]    BURST0_V   = CNT_W'(BURST0_AT);
  localparam logic [BW-1:0]       BURST_END  = BW'(2 * BURST_PULSES);
  localparam logic [FW-1:0]       FILT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0]       HTP_LAST   = HW'(HT_DIV - 1);
  localparam logic [HT_CNT_W-1:0] HT_THR_V   = HT_CNT_W'(HT_THRESHOLD);

  logic                sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                filt_q, filt_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic                carrier_q, carrier_d;
  logic                is_long_q, is_long_d;
  logic                is_long_last_q, is_long_last_d;
  logic                rxd_q, rxd_d;
  logic [BW-1:0]       bph_q, bph_d;
  logic [4:0]          run_q, run_d;
  logic                last_short_q, last_short_d;
  logic                mode_q, mode_d;
  logic                bit_valid_q, bit_valid_d;
  logic                bit_data_q, bit_data_d;
  logic [HW-1:0]       htp_q, htp_d;
  logic [HT_CNT_W-1:0] hcnt_q, hcnt_d;
  logic                high_tone_q, high_tone_d;

  logic             tick, edge_det, cls_short, mode_chg, ht_tick;
  logic [CNT_W-1:0] gap_inc;
  logic [4:0]       run_nx, req;

  always_comb begin
    sync1_d        = cas_in;
    sync2_d        = sync1_q;
    tick           = (presc_q == PRESC_LAST);
    presc_d        = tick ? '0 : presc_q + 1'b1;
    filt_d         = filt_q;
    fcnt_d         = fcnt_q;
    edge_det       = 1'b0;
    gap_d          = gap_q;
    gap_inc        = (gap_q == GAP_MAX_V) ? gap_q : gap_q + 1'b1;
    carrier_d      = carrier_q;
    is_long_d      = is_long_q;
    is_long_last_d = is_long_last_q;
    rxd_d          = rxd_q;
    bph_d          = bph_q;
    run_d          = run_q;
    last_short_d   = last_short_q;
    mode_d         = mode_q;
    mode_chg       = (mode_300 != mode_q);
    bit_valid_d    = 1'b0;
    bit_data_d     = bit_data_q;
    cls_short      = ~is_long_q;
    run_nx         = (cls_short == last_short_q) ? run_q + 5'd1 : 5'd1;
    req            = cls_short ? (mode_300 ? 5'd16 : 5'd4) : (mode_300 ? 5'd8 : 5'd2);

    if (tick) begin
      mode_d = mode_300;
      if (sync2_q == filt_q) begin
        fcnt_d = '0;
      end else if (fcnt_q == FILT_LAST) begin
        fcnt_d   = '0;
        filt_d   = sync2_q;
        edge_det = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end

      // A trigger while a burst is still running is dropped, not queued.
      if (bph_q != '0) begin
        bph_d = (bph_q == BURST_END) ? '0 : bph_q + 1'b1;
      end else if (carrier_q && (gap_q == BURST0_V || gap_q == LONG_MIN_V)) begin
        bph_d = BW'(1);
      end

      if (edge_det) begin
        gap_d = '0;
        if (!carrier_q) begin
          carrier_d = 1'b1;
        end else begin
          is_long_last_d = is_long_q;
          is_long_d      = 1'b0;
          last_short_d   = cls_short;
          if (is_long_q)            rxd_d = invert;
          else if (!is_long_last_q) rxd_d = ~invert;
          if (mode_chg) begin
            run_d = '0;
          end else if (run_nx == req) begin
            bit_valid_d = 1'b1;
            bit_data_d  = cls_short ^ invert;
            run_d       = '0;
          end else begin
            run_d = run_nx;
          end
        end
      end else begin
        gap_d = gap_inc;
        if (gap_inc == LONG_MIN_V) is_long_d = 1'b1;
        if (gap_inc == GAP_MAX_V) begin
          carrier_d = 1'b0;
          is_long_d = 1'b0;
          run_d     = '0;
        end
      end

      if (mode_chg) run_d = '0;
    end

    ht_tick = (htp_q == HTP_LAST);
    htp_d   = ht_tick ? '0 : htp_q + 1'b1;
    hcnt_d  = hcnt_q;
    if (ht_tick) begin
      if ((rxd_q ^ invert) == 1'b0)      hcnt_d = '0;
      else if (hcnt_q != {HT_CNT_W{1'b1}}) hcnt_d = hcnt_q + 1'b1;
    end
    high_tone_d = (hcnt_d >= HT_THR_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;  sync2_q <= 1'b0;  presc_q <= '0;
      filt_q <= 1'b0;   fcnt_q <= '0;     gap_q <= GAP_MAX_V;
      carrier_q <= 1'b0;  is_long_q <= 1'b0;  is_long_last_q <= 1'b1;
      rxd_q <= 1'b1;    bph_q <= '0;      run_q <= '0;
      last_short_q <= 1'b0;  mode_q <= 1'b0;
      bit_valid_q <= 1'b0;   bit_data_q <= 1'b0;
      htp_q <= '0;      hcnt_q <= '0;     high_tone_q <= 1'b0;
    end else if (!enable) begin
      sync1_q <= 1'b0;  sync2_q <= 1'b0;  presc_q <= '0;
      filt_q <= 1'b0;   fcnt_q <= '0;     gap_q <= GAP_MAX_V;
      carrier_q <= 1'b0;  is_long_q <= 1'b0;  is_long_last_q <= 1'b1;
      rxd_q <= 1'b1;    bph_q <= '0;      run_q <= '0;
      last_short_q <= 1'b0;  mode_q <= 1'b0;
      bit_valid_q <= 1'b0;   bit_data_q <= 1'b0;
      htp_q <= '0;      hcnt_q <= '0;     high_tone_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;  sync2_q <= sync2_d;  presc_q <= presc_d;
      filt_q <= filt_d;    fcnt_q <= fcnt_d;    gap_q <= gap_d;
      carrier_q <= carrier_d;  is_long_q <= is_long_d;  is_long_last_q <= is_long_last_d;
      rxd_q <= rxd_d;      bph_q <= bph_d;      run_q <= run_d;
      last_short_q <= last_short_d;  mode_q <= mode_d;
      bit_valid_q <= bit_valid_d;    bit_data_q <= bit_data_d;
      htp_q <= htp_d;      hcnt_q <= hcnt_d;    high_tone_q <= high_tone_d;
    end
  end

  // rxc is low on the odd ticks of a burst and high whenever no burst runs.
  assign rxc       = ~bph_q[0];
  assign rxd       = rxd_q;
  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign carrier   = carrier_q;
  assign high_tone = high_tone_q;

endmodule

// File: tb/tb_cas_fsk_separator.sv
// Directed bench for cas_fsk_separator; high-tone divider shortened to 16 clks to keep the run short.
module tb_cas_fsk_separator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic mode_300 = 1'b0;
  logic invert = 1'b0;
  logic cas_in = 1'b0;
  logic rxd, rxc, bit_valid, bit_data, carrier, high_tone;

  int n_checks = 0;
  int n_fail = 0;
  int since = 0;
  int nn = 0;
  int n_ones = 0, n_zeros = 0, n_rxc = 0, n_wide = 0;
  logic bv_prev = 1'b0;
  logic rxc_prev = 1'b1;
  int r, b1, b0;

  cas_fsk_separator #(.HT_DIV(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_300(mode_300),
    .invert(invert), .cas_in(cas_in), .rxd(rxd), .rxc(rxc),
    .bit_valid(bit_valid), .bit_data(bit_data), .carrier(carrier),
    .high_tone(high_tone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bit_valid) begin
      if (bit_data) n_ones <= n_ones + 1;
      else          n_zeros <= n_zeros + 1;
      if (bv_prev)  n_wide <= n_wide + 1;
    end
    if (rxc_prev && !rxc) n_rxc <= n_rxc + 1;
    bv_prev  <= bit_valid;
    rxc_prev <= rxc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    since += n;
    nn += n;
  endtask

  task automatic tgl();
    cas_in = ~cas_in;
    since = 0;
  endtask

  task automatic tgl_at(input int gap);
    step(gap - since);
    tgl();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cas_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    since = 0;
    nn = 0;
  endtask

  initial begin
    // Reset state and 1200-baud stream: 8 short gaps then 4 long gaps.
    do_reset();
    check_eq("rst_rxd", 32'(rxd), 1);
    check_eq("rst_rxc", 32'(rxc), 1);
    check_eq("rst_carrier", 32'(carrier), 0);
    check_eq("rst_bit_valid", 32'(bit_valid), 0);
    check_eq("rst_high_tone", 32'(high_tone), 0);
    b1 = n_ones; b0 = n_zeros;
    tgl_at(8);
    step(9);
    check_eq("carrier_before_edge1", 32'(carrier), 0);
    step(1);
    check_eq("carrier_at_edge1", 32'(carrier), 1);
    repeat (7) tgl_at(256);
    r = n_rxc;
    tgl_at(256);
    check_eq("rxc_lows_short_gap", n_rxc - r, 4);
    step(20);
    check_eq("s1200_short_ones", n_ones - b1, 2);
    check_eq("s1200_short_zeros", n_zeros - b0, 0);
    check_eq("s1200_short_rxd", 32'(rxd), 1);
    tgl_at(512);
    r = n_rxc;
    tgl_at(512);
    check_eq("rxc_lows_long_gap", n_rxc - r, 8);
    tgl_at(512);
    tgl_at(512);
    step(20);
    check_eq("s1200_long_zeros", n_zeros - b0, 2);
    check_eq("s1200_long_ones", n_ones - b1, 2);
    check_eq("s1200_long_rxd", 32'(rxd), 0);

    // Carrier drops exactly 600 ticks after the last accepted edge.
    step(1209 - since);
    check_eq("carrier_599_ticks", 32'(carrier), 1);
    step(1);
    check_eq("carrier_lost_600_ticks", 32'(carrier), 0);

    // Asynchronous reset in the middle of a live stream.
    tgl();
    step(12);
    check_eq("pre_reset_carrier", 32'(carrier), 1);
    check_eq("pre_reset_rxd", 32'(rxd), 0);
    #2;
    reset = 1'b1;
    cas_in = 1'b0;
    #1;
    check_eq("async_rst_rxd", 32'(rxd), 1);
    check_eq("async_rst_rxc", 32'(rxc), 1);
    check_eq("async_rst_carrier", 32'(carrier), 0);
    check_eq("async_rst_bit_valid", 32'(bit_valid), 0);
    check_eq("async_rst_high_tone", 32'(high_tone), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 300-baud framing, then a mode change that must discard a partial run.
    mode_300 = 1'b1;
    do_reset();
    b1 = n_ones; b0 = n_zeros;
    tgl_at(8);
    repeat (16) tgl_at(256);
    step(20);
    check_eq("s300_short_ones", n_ones - b1, 1);
    check_eq("s300_short_zeros", n_zeros - b0, 0);
    repeat (8) tgl_at(512);
    step(20);
    check_eq("s300_long_zeros", n_zeros - b0, 1);
    check_eq("s300_long_ones", n_ones - b1, 1);
    tgl_at(512);
    step(100);
    mode_300 = 1'b0;
    tgl_at(512);
    step(20);
    check_eq("mode_change_clears_run", n_zeros - b0, 1);
    tgl_at(512);
    step(20);
    check_eq("after_mode_change_bit", n_zeros - b0, 2);

    // Glitch rejection: 3-tick pulses ignored, 4-tick pulse accepted.
    do_reset();
    tgl_at(8);
    step(6);
    tgl();
    step(20);
    check_eq("glitch3_no_carrier", 32'(carrier), 0);
    tgl();
    step(8);
    tgl();
    step(20);
    check_eq("pulse4_carrier", 32'(carrier), 1);
    tgl_at(256);
    r = n_rxc;
    step(100);
    tgl();
    step(6);
    tgl();
    step(150);
    check_eq("glitch3_rxc_unaffected", n_rxc - r, 4);
    check_eq("glitch3_carrier_kept", 32'(carrier), 1);

    // High tone: 445 samples of mark, then one long gap clears it.
    do_reset();
    tgl_at(8);
    repeat (27) tgl_at(256);
    step(7119 - nn);
    check_eq("ht_before_threshold", 32'(high_tone), 0);
    step(1);
    check_eq("ht_at_threshold", 32'(high_tone), 1);
    tgl_at(256);
    tgl_at(512);
    check_eq("ht_before_long_edge", 32'(high_tone), 1);
    step(27);
    check_eq("ht_long_rxd", 32'(rxd), 0);
    check_eq("ht_cleared", 32'(high_tone), 0);

    // Inverted tones.
    invert = 1'b1;
    do_reset();
    check_eq("inv_rst_rxd", 32'(rxd), 1);
    b1 = n_ones; b0 = n_zeros;
    tgl_at(8);
    repeat (8) tgl_at(256);
    step(20);
    check_eq("inv_short_zeros", n_zeros - b0, 2);
    check_eq("inv_short_ones", n_ones - b1, 0);
    check_eq("inv_short_rxd", 32'(rxd), 0);
    repeat (4) tgl_at(512);
    step(20);
    check_eq("inv_long_ones", n_ones - b1, 2);
    check_eq("inv_long_rxd", 32'(rxd), 1);

    check_eq("bit_valid_single_clk", n_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
